id_ex_stage: RTL and testbench

- ID/EX pipeline register with EX-side operand forwarding for the pipelined CPU.
- Captures decoded operands and control from ID each cycle, then applies EX/MEM and MEM/WB forwarding. Drives the ALU's a, b and 3-bit control inputs, plus the store data and control fields that flow on to the EX/MEM register.
- Also detects load-use hazards so that the pipeline controller can stall IF/ID.

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Registered operands are resolved against the live EX/MEM and MEM/WB results before they drive the ALU.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [2:0]        id_alu_ctrl_i,
    input  logic              id_alu_src_i,
    input  logic              id_reg_write_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [2:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_valid_o,
    output logic              ex_reg_write_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              hazard_o
);

    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_ctrl;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
    } idex_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

    idex_t    idex_q;
    idex_t    idex_d;
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Flush clears only valid and control; data fields keep their old contents.
    always_comb begin
        // NOTE: every field starts from its held value so no path through this block can infer a latch.
        idex_d = idex_q;
        if (flush_i) begin
            idex_d.valid      = 1'b0;
            idex_d.alu_ctrl   = 3'b000;
            idex_d.alu_src    = 1'b0;
            idex_d.reg_write  = 1'b0;
            idex_d.mem_read   = 1'b0;
            idex_d.mem_write  = 1'b0;
            idex_d.mem_to_reg = 1'b0;
        end else if (!stall_i) begin
            idex_d.valid      = id_valid_i;
            idex_d.alu_ctrl   = id_alu_ctrl_i;
            idex_d.alu_src    = id_alu_src_i;
            idex_d.reg_write  = id_reg_write_i;
            idex_d.mem_read   = id_mem_read_i;
            idex_d.mem_write  = id_mem_write_i;
            idex_d.mem_to_reg = id_mem_to_reg_i;
            idex_d.rs1        = id_rs1_i;
            idex_d.rs2        = id_rs2_i;
            idex_d.rd         = id_rd_i;
            idex_d.rs1_data   = id_rs1_data_i;
            idex_d.rs2_data   = id_rs2_data_i;
            idex_d.imm        = id_imm_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking update so every register samples the pre-edge value of its inputs.
        if (rst_i) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // EX/MEM is the younger producer and therefore beats MEM/WB; x0 never forwards.
    always_comb begin
        sel_a = FWD_RF;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == idex_q.rs1)) begin
            sel_a = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == idex_q.rs1)) begin
            sel_a = FWD_MEMWB;
        end
    end

    always_comb begin
        sel_b = FWD_RF;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == idex_q.rs2)) begin
            sel_b = FWD_EXMEM;
        end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == idex_q.rs2)) begin
            sel_b = FWD_MEMWB;
        end
    end

    always_comb begin
        unique case (sel_a)
            FWD_EXMEM: fwd_a = exmem_result_i;
            FWD_MEMWB: fwd_a = memwb_data_i;
            default:   fwd_a = idex_q.rs1_data;
        endcase
        unique case (sel_b)
            FWD_EXMEM: fwd_b = exmem_result_i;
            FWD_MEMWB: fwd_b = memwb_data_i;
            default:   fwd_b = idex_q.rs2_data;
        endcase
    end

    assign alu_a_o      = fwd_a;
    assign alu_b_o      = idex_q.alu_src ? idex_q.imm : fwd_b;
    assign store_data_o = fwd_b;
    assign alu_ctrl_o   = idex_q.alu_ctrl;
    assign ex_rd_o      = idex_q.rd;
    assign ex_valid_o   = idex_q.valid;

    assign ex_reg_write_o  = idex_q.valid & idex_q.reg_write;
    assign ex_mem_read_o   = idex_q.valid & idex_q.mem_read;
    assign ex_mem_write_o  = idex_q.valid & idex_q.mem_write;
    assign ex_mem_to_reg_o = idex_q.valid & idex_q.mem_to_reg;

    // A load in EX cannot supply its data to the instruction now in ID in time.
    assign hazard_o = ex_valid_o & ex_mem_read_o & (idex_q.rd != '0) &
                      ((idex_q.rd == id_rs1_i) | (idex_q.rd == id_rs2_i));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall, flush, id_valid;
    logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [2:0]        id_alu_ctrl;
    logic              id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic              exmem_rw, memwb_rw;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic [DATA_W-1:0] exmem_result, memwb_data;

    logic [DATA_W-1:0] alu_a, alu_b, store_data;
    logic [2:0]        alu_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
        .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data), .id_imm_i(id_imm),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd), .id_alu_ctrl_i(id_alu_ctrl),
        .id_alu_src_i(id_alu_src), .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
        .id_mem_write_i(id_mem_write), .id_mem_to_reg_i(id_mem_to_reg),
        .exmem_reg_write_i(exmem_rw), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
        .memwb_reg_write_i(memwb_rw), .memwb_rd_i(memwb_rd), .memwb_data_i(memwb_data),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl), .store_data_o(store_data),
        .ex_rd_o(ex_rd), .ex_valid_o(ex_valid), .ex_reg_write_o(ex_reg_write),
        .ex_mem_read_o(ex_mem_read), .ex_mem_write_o(ex_mem_write),
        .ex_mem_to_reg_o(ex_mem_to_reg), .hazard_o(hazard)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the instruction currently sitting in EX.
    logic              m_valid = 1'b0, m_known = 1'b0;
    logic [2:0]        m_ctrl = '0;
    logic              m_src = 1'b0, m_rw = 1'b0, m_mr = 1'b0, m_mw = 1'b0, m_mtr = 1'b0;
    logic [REG_AW-1:0] m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [DATA_W-1:0] m_d1 = '0, m_d2 = '0, m_imm = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_known <= 1'b1; m_ctrl <= '0; m_src <= 1'b0;
            m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_mtr <= 1'b0;
            m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_d1 <= '0; m_d2 <= '0; m_imm <= '0;
        end else if (flush) begin
            m_valid <= 1'b0; m_known <= 1'b0;
            m_rw <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0; m_mtr <= 1'b0;
        end else if (!stall) begin
            m_valid <= id_valid; m_known <= 1'b1; m_ctrl <= id_alu_ctrl; m_src <= id_alu_src;
            m_rw <= id_reg_write; m_mr <= id_mem_read; m_mw <= id_mem_write; m_mtr <= id_mem_to_reg;
            m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
            m_d1 <= id_rs1_data; m_d2 <= id_rs2_data; m_imm <= id_imm;
        end
    end

    function automatic logic [DATA_W-1:0] model_fwd(input logic [REG_AW-1:0] r,
                                                    input logic [DATA_W-1:0] rf);
        if (r == 0) return rf;
        if (exmem_rw && exmem_rd == r) return exmem_result;
        if (memwb_rw && memwb_rd == r) return memwb_data;
        return rf;
    endfunction

    // Outputs are compared at the falling edge, when all inputs are settled.
    always @(negedge clk) begin
        check("valid", ex_valid, m_valid);
        check("reg_write", ex_reg_write, m_valid && m_rw);
        check("mem_read", ex_mem_read, m_valid && m_mr);
        check("mem_write", ex_mem_write, m_valid && m_mw);
        check("mem_to_reg", ex_mem_to_reg, m_valid && m_mtr);
        check("hazard", hazard, m_valid && m_mr && m_rd != 0 && (m_rd == id_rs1 || m_rd == id_rs2));
        if (m_known) begin
            check("alu_a", alu_a, model_fwd(m_rs1, m_d1));
            check("alu_b", alu_b, m_src ? m_imm : model_fwd(m_rs2, m_d2));
            check("store_data", store_data, model_fwd(m_rs2, m_d2));
            check("alu_ctrl", alu_ctrl, m_ctrl);
            check("ex_rd", ex_rd, m_rd);
        end
    end

    task automatic set_idle();
        stall = 0; flush = 0; id_valid = 0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_ctrl = '0;
        id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_rw = 0; exmem_rd = '0; exmem_result = '0;
        memwb_rw = 0; memwb_rd = '0; memwb_data = '0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        #2 rst = 1;
        step();
        check("reset_valid", ex_valid, 1'b0);
        check("reset_ctrl", alu_ctrl, 3'b000);
        check("reset_rd", ex_rd, '0);
        check("reset_alu_a", alu_a, '0);
        rst = 0;

        // Plain capture
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 4;
        id_rs1_data = 100; id_rs2_data = 28; id_alu_ctrl = 3'b001;
        step();
        check("cap_alu_a", alu_a, 100);
        check("cap_alu_b", alu_b, 28);
        check("cap_ctrl", alu_ctrl, 3'b001);
        check("cap_valid", ex_valid, 1'b1);

        // Forwarding priority on rs1=5
        id_rs1 = 5; id_rs1_data = 77;
        step();
        exmem_rw = 1; exmem_rd = 5; exmem_result = 56;
        memwb_rw = 1; memwb_rd = 5; memwb_data = 31;
        #1 check("fwd_exmem", alu_a, 56);
        exmem_rw = 0;
        #1 check("fwd_memwb", alu_a, 31);
        exmem_rw = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_x0", alu_a, 77);

        // Immediate select and forwarded store data
        exmem_rw = 0; memwb_rw = 0;
        id_alu_src = 1; id_imm = 32'hFFFF_FFFC; id_rs2 = 7; id_rs2_data = 9; id_mem_write = 1;
        step();
        memwb_rw = 1; memwb_rd = 7; memwb_data = 32'h55;
        #1 check("imm_alu_b", alu_b, 32'hFFFF_FFFC);
        check("imm_store", store_data, 32'h55);
        memwb_rw = 0;

        // Load-use hazard
        id_alu_src = 0; id_mem_write = 0; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
        id_rd = 3; id_rs1 = 6; id_rs2 = 1;
        step();
        id_mem_read = 0; id_mem_to_reg = 0; id_rd = 0; id_rs2 = 3;
        #1 check("hazard_set", hazard, 1'b1);
        id_mem_read = 1; id_rs1 = 0; id_rs2 = 0;
        step();
        #1 check("hazard_x0", hazard, 1'b0);

        // Stall holds, stall+flush bubbles
        id_mem_read = 0; id_reg_write = 1; id_alu_ctrl = 3'b101; id_rs1 = 9; id_rs1_data = 32'h1234;
        step();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            id_alu_ctrl = 3'(i + 2); id_rs1_data = $urandom; id_reg_write = 0;
            step();
            check("stall_alu_a", alu_a, 32'h1234);
            check("stall_ctrl", alu_ctrl, 3'b101);
            check("stall_valid", ex_valid, 1'b1);
        end
        flush = 1;
        step();
        check("flush_valid", ex_valid, 1'b0);
        check("flush_rw", ex_reg_write, 1'b0);
        stall = 0; flush = 0;

        // Asynchronous reset between edges
        id_valid = 1; id_reg_write = 1;
        step();
        check("pre_rst_valid", ex_valid, 1'b1);
        #2 rst = 1;
        #1 check("arst_valid", ex_valid, 1'b0);
        check("arst_rw", ex_reg_write, 1'b0);
        step();
        check("rst_hold_valid", ex_valid, 1'b0);
        rst = 0;
        #1 check("post_rst_valid", ex_valid, 1'b0);
        step();
        check("recap_valid", ex_valid, 1'b1);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            step();
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = $urandom_range(0, 1);
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            id_rs1 = REG_AW'($urandom_range(0, 7));
            id_rs2 = REG_AW'($urandom_range(0, 7));
            id_rd = REG_AW'($urandom_range(0, 7));
            id_alu_ctrl = 3'($urandom_range(0, 7));
            id_alu_src = $urandom_range(0, 1); id_reg_write = $urandom_range(0, 1);
            id_mem_read = $urandom_range(0, 1); id_mem_write = $urandom_range(0, 1);
            id_mem_to_reg = $urandom_range(0, 1);
            exmem_rw = $urandom_range(0, 1); exmem_rd = REG_AW'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_rw = $urandom_range(0, 1); memwb_rd = REG_AW'($urandom_range(0, 7));
            memwb_data = $urandom;
        end
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
